haar_feature_sum_pipe: RTL and testbench
========================================

Name: haar_feature_sum_pipe

Overview:
Parametrised Haar-feature evaluator for the Viola-Jones cascade datapath. Consumes a stream of integral-image corner values, forms each rectangle sum (A - B + C - D), applies a signed per-rectangle weight and accumulates the weighted sums into one saturated feature sum. Supports 1..MAX_RECT rectangles per feature, selected at run time. Sits between the integral-image fetch unit and the stage-threshold comparator, with credit-based backpressure and an output FIFO.

Parameters:
DATA_W, 32, width of integral-image corner values (unsigned)
WEIGHT_W, 8, width of each signed rectangle weight
MAX_RECT, 3, maximum rectangles per feature (>=1)
SUM_W, 40, width of signed feature-sum output
ID_W, 12, width of feature identifier
OUT_DEPTH, 2, output FIFO depth (>=2)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
pt_val_i  in  1  corner point valid
pt_rdy_o  out  1  corner point ready
pt_data_i  in  DATA_W  corner value
pt_sof_i  in  1  first corner of a new feature; qualifies the config inputs
num_rect_i  in  $clog2(MAX_RECT+1)  rectangle count, sampled on sof beat
weights_i  in  MAX_RECT*WEIGHT_W  signed weights, rect k at [k*WEIGHT_W +: WEIGHT_W], sampled on sof beat
feat_id_i  in  ID_W  feature id, sampled on sof beat
sum_val_o  out  1  result valid
sum_rdy_i  in  1  result ready
sum_data_o  out  SUM_W  signed saturated feature sum
sum_id_o  out  ID_W  id of the feature producing sum_data_o
err_o  out  1  sticky protocol error flag

Behaviour:
- Interface: asynchronous reset, active low (rst_n_i); single clock clk_i. Reset clears all state; outputs reset to pt_rdy_o=0, sum_val_o=0, sum_data_o=0, sum_id_o=0, err_o=0. pt_rdy_o rises on the first clock after reset release.
- Reset mid-feature discards all in-flight points, pipeline contents and FIFO entries.
- Beat accepted when pt_val_i & pt_rdy_o. Corner order inside a rect: 0=A,1=B,2=C,3=D. Rects arrive in order 0..num_rect-1.
- FSM IDLE/COLLECT.
- IDLE, accepted beat with sof and 1<=num_rect_i<=MAX_RECT: latch config, store corner 0 of rect 0, go COLLECT.
- IDLE, accepted beat without sof: drop it, set err_o.
- IDLE, sof with num_rect_i=0 or num_rect_i>MAX_RECT: drop it, set err_o, stay IDLE.
- COLLECT: corner counter 0..3 and rect counter advance per beat. Corners A, B, C are registered.
- COLLECT, corner D: issue rect (A-B+C-D, DATA_W+2 bits signed) to pipeline S1 with the rect index.
- COLLECT, D of last rect: also issue the last flag and return to IDLE.
- COLLECT, sof beat: abandon the current feature (flush its partial accumulator, release its credit), set err_o, treat the beat as a new IDLE sof.
- Pipeline: S1 rect sum. S2 product = rect_sum * weight[k], signed, DATA_W+2+WEIGHT_W bits. S3 accumulator: first rect loads, later rects add; result saturates to the signed SUM_W range at every add.
- On last, S3 pushes {sat_sum, id} into the FIFO and the accumulator clears.
- Latency: last D accepted at edge t -> sum_val_o high after edge t+3 when the FIFO was empty. Throughput is one point per cycle with no bubbles between features.
- Credits: a feature occupies a credit from its sof beat until its FIFO entry pops. pt_rdy_o = 0 whenever (FIFO count + features in flight, including the collecting one) == OUT_DEPTH and the next beat would be sof. Non-sof beats of an already-credited feature are never stalled.
- Output: FIFO is first-word-fall-through; pop on sum_val_o & sum_rdy_i. sum_data_o/sum_id_o hold stable while sum_val_o & !sum_rdy_i.
- FIFO push and pop in the same cycle: allowed, count unchanged.
- err_o is sticky until reset; it does not block operation.

Test Plan:
- Two-rect feature: rect0 corners 100,40,10,20 (sum 50), rect1 corners 60,10,5,15 (sum 40), weights -1,+2, id 7, sum_rdy_i=1 -> sum_data_o=30, sum_id_o=7, sum_val_o one cycle, 3 cycles after the last D.
- Back-to-back three-rect features with continuous pt_val_i and sum_rdy_i=1 -> pt_rdy_o never drops; results in order, one per 12 beats.
- sum_rdy_i=0, feed 3 features with OUT_DEPTH=2 -> pt_rdy_o low on the third sof; two entries held stable; raising sum_rdy_i drains them and the third feature completes correctly.
- Corners 2^32-1,0,2^32-1,0 with weight +127 on 3 rects, SUM_W=40 -> sum_data_o=2^39-1 (saturated); negative mirror -> -2^39.
- Protocol errors: non-sof beat in IDLE, num_rect_i=0, sof mid-feature -> err_o set and held; only the restarted feature produces a correct result.
- rst_n_i pulsed low mid-COLLECT with one FIFO entry pending -> all outputs 0 asynchronously; the next clean feature is computed correctly.

Source files
------------

// File: rtl/haar_feature_sum_pipe.sv
// Haar-feature evaluator: rectangle sums (A-B+C-D) from integral-image corners, signed
// weighting, saturated accumulation, credit-gated input and a first-word-fall-through result FIFO.
module haar_feature_sum_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned MAX_RECT  = 3,
  parameter int unsigned SUM_W     = 40,
  parameter int unsigned ID_W      = 12,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           pt_val_i,
  output logic                           pt_rdy_o,
  input  logic [DATA_W-1:0]              pt_data_i,
  input  logic                           pt_sof_i,
  input  logic [$clog2(MAX_RECT+1)-1:0]  num_rect_i,
  input  logic [MAX_RECT*WEIGHT_W-1:0]   weights_i,
  input  logic [ID_W-1:0]                feat_id_i,
  output logic                           sum_val_o,
  input  logic                           sum_rdy_i,
  output logic [SUM_W-1:0]               sum_data_o,
  output logic [ID_W-1:0]                sum_id_o,
  output logic                           err_o
);

  localparam int unsigned RW     = $clog2(MAX_RECT+1);
  localparam int unsigned RS_W   = DATA_W + 2;
  localparam int unsigned PROD_W = RS_W + WEIGHT_W;
  localparam int unsigned EXT_W  = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 1;
  localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W  = $clog2(OUT_DEPTH+1);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StCollect = 1'b1;

  localparam logic [RW-1:0]           MaxRect = RW'(MAX_RECT);
  localparam logic [CNT_W-1:0]        Depth   = CNT_W'(OUT_DEPTH);
  localparam logic signed [EXT_W-1:0] SatMax  = EXT_W'({1'b0, {(SUM_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] SatMin  = ~SatMax;

  // Front end: corner collection
  logic [0:0]                 state_q, state_d;
  logic                       rdy_en_q, err_q, err_d;
  logic [1:0]                 corner_q, corner_d;
  logic [RW-1:0]              rect_q, rect_d, num_rect_q, num_rect_d;
  logic [MAX_RECT*WEIGHT_W-1:0] weights_q, weights_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic [DATA_W-1:0]          a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CNT_W-1:0]           credits_q, credits_d;

  // Pipeline stages
  logic                       s1_val_q, s1_val_d, s1_first_q, s1_last_q;
  logic signed [RS_W-1:0]     s1_sum_q, rect_sum;
  logic signed [WEIGHT_W-1:0] s1_w_q, w_sel;
  logic [ID_W-1:0]            s1_id_q;
  logic                       s2_val_q, s2_first_q, s2_last_q;
  logic signed [PROD_W-1:0]   s2_prod_q;
  logic [ID_W-1:0]            s2_id_q;
  logic signed [SUM_W-1:0]    acc_q, acc_d;
  logic signed [EXT_W-1:0]    sum_ext;
  logic                       res_val_q;
  logic [ID_W-1:0]            res_id_q;

  // Output FIFO
  logic [SUM_W-1:0]           data_mem_q [OUT_DEPTH];
  logic [ID_W-1:0]            id_mem_q   [OUT_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           cnt_q;

  logic beat, sof_ok, last_rect, take, release_cr, push, pop;

  // A new feature may only start while a credit is free; mid-feature beats never stall.
  assign pt_rdy_o  = rdy_en_q & ~((state_q == StIdle) & (credits_q >= Depth));
  assign beat      = pt_val_i & pt_rdy_o;
  assign sof_ok    = (num_rect_i != '0) && (num_rect_i <= MaxRect);
  assign last_rect = (rect_q == num_rect_q - 1'b1);
  assign rect_sum  = RS_W'(a_q) - RS_W'(b_q) + RS_W'(c_q) - RS_W'(pt_data_i);

  assign push = res_val_q;
  assign pop  = sum_val_o & sum_rdy_i;

  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < MAX_RECT; k++) begin
      if (rect_q == RW'(k)) w_sel = weights_q[k*WEIGHT_W +: WEIGHT_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    corner_d   = corner_q;
    rect_d     = rect_q;
    num_rect_d = num_rect_q;
    weights_d  = weights_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    s1_val_d   = 1'b0;
    take       = 1'b0;
    release_cr = 1'b0;
    if (beat) begin
      if (pt_sof_i) begin
        // A sof while collecting abandons the current feature and frees its credit.
        if (state_q == StCollect) begin
          err_d      = 1'b1;
          release_cr = 1'b1;
        end
        if (sof_ok) begin
          num_rect_d = num_rect_i;
          weights_d  = weights_i;
          id_d       = feat_id_i;
          a_d        = pt_data_i;
          corner_d   = 2'd1;
          rect_d     = '0;
          state_d    = StCollect;
          take       = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end else if (state_q == StIdle) begin
        err_d = 1'b1;
      end else begin
        corner_d = corner_q + 2'd1;
        unique case (corner_q)
          2'd0: a_d = pt_data_i;
          2'd1: b_d = pt_data_i;
          2'd2: c_d = pt_data_i;
          2'd3: begin
            s1_val_d = 1'b1;
            rect_d   = rect_q + 1'b1;
            if (last_rect) state_d = StIdle;
          end
        endcase
      end
    end
    credits_d = credits_q + CNT_W'(take) - CNT_W'(release_cr) - CNT_W'(pop);
  end

  // First rect of a feature loads the accumulator, so abandoned partials never leak.
  always_comb begin
    if (s2_first_q) sum_ext = EXT_W'(s2_prod_q);
    else            sum_ext = EXT_W'(s2_prod_q) + EXT_W'(acc_q);
    if (sum_ext > SatMax)      acc_d = SatMax[SUM_W-1:0];
    else if (sum_ext < SatMin) acc_d = SatMin[SUM_W-1:0];
    else                       acc_d = sum_ext[SUM_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      rdy_en_q   <= 1'b0;
      err_q      <= 1'b0;
      corner_q   <= '0;
      rect_q     <= '0;
      num_rect_q <= '0;
      weights_q  <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      credits_q  <= '0;
      s1_val_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      s1_w_q     <= '0;
      s1_id_q    <= '0;
      s2_val_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
      acc_q      <= '0;
      res_val_q  <= 1'b0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      err_q      <= err_d;
      corner_q   <= corner_d;
      rect_q     <= rect_d;
      num_rect_q <= num_rect_d;
      weights_q  <= weights_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      credits_q  <= credits_d;
      s1_val_q   <= s1_val_d;
      if (s1_val_d) begin
        s1_first_q <= (rect_q == '0);
        s1_last_q  <= last_rect;
        s1_sum_q   <= rect_sum;
        s1_w_q     <= w_sel;
        s1_id_q    <= id_q;
      end
      s2_val_q <= s1_val_q;
      if (s1_val_q) begin
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_prod_q  <= PROD_W'(s1_sum_q) * PROD_W'(s1_w_q);
        s2_id_q    <= s1_id_q;
      end
      res_val_q <= s2_val_q & s2_last_q;
      if (s2_val_q) begin
        acc_q    <= acc_d;
        res_id_q <= s2_id_q;
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        id_mem_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= acc_q;
        id_mem_q[wr_ptr_q]   <= res_id_q;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign sum_val_o  = (cnt_q != '0);
  assign sum_data_o = data_mem_q[rd_ptr_q];
  assign sum_id_o   = id_mem_q[rd_ptr_q];
  assign err_o      = err_q;

endmodule

// File: tb/tb_haar_feature_sum_pipe.sv
// Directed bench for haar_feature_sum_pipe: scoreboard of modelled feature sums checked as
// results pop, plus latency, backpressure, saturation, protocol-error and reset checks.
module tb_haar_feature_sum_pipe;

  localparam int DATA_W = 32, WEIGHT_W = 8, MAX_RECT = 3, SUM_W = 40, ID_W = 12, OUT_DEPTH = 2;
  localparam logic [31:0] MaxV = 32'hFFFF_FFFF;

  logic        clk, rst_n, pt_val, pt_rdy, pt_sof, sum_val, sum_rdy, err;
  logic [31:0] pt_data;
  logic [1:0]  num_rect;
  logic [23:0] weights;
  logic [11:0] feat_id, sum_id;
  logic [39:0] sum_data;

  typedef struct packed {
    logic [39:0] data;
    logic [11:0] id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cor [12];
  int          errors = 0;
  int          checks = 0;
  int          stalls = 0;

  haar_feature_sum_pipe #(
    .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .MAX_RECT(MAX_RECT),
    .SUM_W(SUM_W), .ID_W(ID_W), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pt_val_i(pt_val), .pt_rdy_o(pt_rdy),
    .pt_data_i(pt_data), .pt_sof_i(pt_sof), .num_rect_i(num_rect), .weights_i(weights),
    .feat_id_i(feat_id), .sum_val_o(sum_val), .sum_rdy_i(sum_rdy), .sum_data_o(sum_data),
    .sum_id_o(sum_id), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: per-rect sum * weight, load on rect 0, saturate to 40-bit signed after each step.
  function automatic logic [39:0] model(input int nr, input logic [23:0] w);
    longint acc, rs, wk, p;
    longint maxv = (longint'(1) <<< 39) - 1;
    longint minv = -(longint'(1) <<< 39);
    acc = 0;
    for (int k = 0; k < nr; k++) begin
      rs = longint'(cor[4*k]) - longint'(cor[4*k+1]) + longint'(cor[4*k+2])
           - longint'(cor[4*k+3]);
      wk = longint'($signed(w[8*k +: 8]));
      p  = rs * wk;
      acc = (k == 0) ? p : acc + p;
      if (acc > maxv) acc = maxv;
      if (acc < minv) acc = minv;
    end
    return acc[39:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sum_val && sum_rdy) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed=%0h/%0h expected=none", sum_data, sum_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum_data", 64'(sum_data), 64'(e.data));
        chk("sum_id", 64'(sum_id), 64'(e.id));
      end
    end
  end

  task automatic idle();
    pt_val = 1'b0;
    pt_sof = 1'b0;
  endtask

  // Holds pt_val high until the beat is accepted; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic sof, input logic [1:0] nr,
                           input logic [23:0] w, input logic [11:0] id);
    bit done = 0;
    pt_val = 1'b1; pt_data = d; pt_sof = sof; num_rect = nr; weights = w; feat_id = id;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (pt_rdy) done = 1;
      else stalls++;
    end
    if (!done) chk("beat_timeout", 64'(pt_rdy), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_feature(input int nr, input logic [23:0] w, input logic [11:0] id,
                              input int nbeats, input bit push);
    if (push) sb.push_back('{data: model(nr, w), id: id});
    for (int b = 0; b < nbeats; b++) send_beat(cor[b], (b == 0), 2'(nr), w, id);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sum_rdy = 1'b0; pt_data = '0; num_rect = '0; weights = '0; feat_id = '0;
    idle();
    #12;
    chk("rst_pt_rdy", 64'(pt_rdy), 64'd0);
    chk("rst_sum_val", 64'(sum_val), 64'd0);
    chk("rst_sum_data", 64'(sum_data), 64'd0);
    chk("rst_sum_id", 64'(sum_id), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", 64'(pt_rdy), 64'd1);
    @(posedge clk);
    #1;

    // Two-rect feature, result 30, exactly 3 cycles after the last D.
    sum_rdy = 1'b1;
    cor = '{100, 40, 10, 20, 60, 10, 5, 15, 0, 0, 0, 0};
    send_feature(2, 24'h0002FF, 12'd7, 8, 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("latency_early", 64'(sum_val), 64'd0);
    end
    @(negedge clk);
    chk("latency_valid", 64'(sum_val), 64'd1);
    chk("two_rect_value", 64'(sum_data), 64'(40'd30));
    @(negedge clk);
    chk("single_cycle_valid", 64'(sum_val), 64'd0);
    chk("no_err_clean", 64'(err), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back three-rect features with continuous valid.
    stalls = 0;
    cor = '{1000, 100, 50, 300, 7, 3, 9, 1, 500, 499, 2, 0};
    send_feature(3, 24'h05_FD_02, 12'd21, 12, 1);
    cor = '{90, 80, 70, 60, 12345, 0, 0, 45, 8, 8, 8, 8};
    send_feature(3, 24'h80_7F_01, 12'd22, 12, 1);
    cor = '{3, 2, 1, 0, 400, 1, 1, 300, 77, 7, 0, 60};
    send_feature(3, 24'hF0_0A_C4, 12'd23, 12, 1);
    idle();
    chk("no_stall_b2b", 64'(stalls), 64'd0);
    drain();

    // Backpressure: two results held, third sof stalled until the FIFO drains.
    sum_rdy = 1'b0;
    cor = '{9, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    send_feature(1, 24'h000003, 12'd1, 4, 1);
    cor = '{20, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    send_feature(1, 24'h0000FE, 12'd2, 4, 1);
    cor = '{7, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    sb.push_back('{data: model(1, 24'h000004), id: 12'd9});
    pt_val = 1'b1; pt_sof = 1'b1; pt_data = cor[0]; num_rect = 2'd1;
    weights = 24'h000004; feat_id = 12'd9;
    @(negedge clk);
    chk("rdy_low_third_sof", 64'(pt_rdy), 64'd0);
    repeat (5) @(negedge clk);
    chk("rdy_still_low", 64'(pt_rdy), 64'd0);
    chk("held_valid", 64'(sum_val), 64'd1);
    chk("held_data", 64'(sum_data), 64'(40'd15));
    chk("held_id", 64'(sum_id), 64'd1);
    @(posedge clk);
    #1;
    sum_rdy = 1'b1;
    send_feature(1, 24'h000004, 12'd9, 4, 0);
    idle();
    drain();

    // Saturation in both directions.
    cor = '{MaxV, 0, MaxV, 0, MaxV, 0, MaxV, 0, MaxV, 0, MaxV, 0};
    send_feature(3, 24'h7F7F7F, 12'h55, 12, 1);
    cor = '{0, MaxV, 0, MaxV, 0, MaxV, 0, MaxV, 0, MaxV, 0, MaxV};
    send_feature(3, 24'h7F7F7F, 12'h56, 12, 1);
    idle();
    drain();

    // Protocol errors.
    do_reset();
    chk("err_clear", 64'(err), 64'd0);
    send_beat(32'd5, 1'b0, 2'd1, 24'h000001, 12'd0);
    idle();
    @(negedge clk);
    chk("err_nonsof_idle", 64'(err), 64'd1);
    @(posedge clk);
    #1;
    do_reset();
    send_beat(32'd5, 1'b1, 2'd0, 24'h000001, 12'd0);
    idle();
    @(negedge clk);
    chk("err_zero_rect", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    chk("zero_rect_no_out", 64'(sum_val), 64'd0);
    @(posedge clk);
    #1;
    do_reset();
    sum_rdy = 1'b1;
    cor = '{100, 1, 1, 1, 50, 2, 2, 2, 0, 0, 0, 0};
    send_feature(2, 24'h000101, 12'd3, 6, 0);
    cor = '{40, 4, 8, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    send_feature(1, 24'h0000FB, 12'd4, 4, 1);
    idle();
    chk("err_sof_mid", 64'(err), 64'd1);
    drain();
    repeat (10) @(negedge clk);

    // Async reset mid-feature with a pending FIFO entry.
    @(posedge clk);
    #1;
    sum_rdy = 1'b0;
    cor = '{50, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_feature(1, 24'h000001, 12'd11, 4, 1);
    idle();
    repeat (5) @(negedge clk);
    chk("pending_valid", 64'(sum_val), 64'd1);
    @(posedge clk);
    #1;
    cor = '{9, 9, 9, 9, 9, 9, 9, 9, 0, 0, 0, 0};
    send_feature(2, 24'h000101, 12'd13, 3, 0);
    #2;
    rst_n = 1'b0;
    idle();
    sb.delete();
    #1;
    chk("async_rst_val", 64'(sum_val), 64'd0);
    chk("async_rst_data", 64'(sum_data), 64'd0);
    chk("async_rst_id", 64'(sum_id), 64'd0);
    chk("async_rst_err", 64'(err), 64'd0);
    chk("async_rst_rdy", 64'(pt_rdy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sum_rdy = 1'b1;
    cor = '{30, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    send_feature(1, 24'h0000FD, 12'd12, 4, 1);
    idle();
    drain();
    chk("final_err_clear", 64'(err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
